// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the icache AXI refill engine and its slots.
// Beat and width helpers are constant functions so they can size ports.
package wt_cache_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_ISSUED  = 2'd2
    } slot_state_e;

    // Debug view of one slot, exported by every slot instance.
    typedef struct packed {
        slot_state_e state;
        logic        nc;
    } refill_slot_t;

    // First error cause seen by a transaction; any non-NONE code returns err=1.
    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_RESP       = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW   = 2'd2;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd3;

    function automatic int unsigned beat_count(int unsigned line_w, int unsigned data_w);
        return line_w / data_w;
    endfunction

    function automatic int unsigned blen_width(int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/icache_refill_slot.sv
// One outstanding refill: request fields, beat buffer, beat counter and error
// tracking, with a FREE -> PENDING -> ISSUED -> FREE lifecycle.
module icache_refill_slot
    import wt_cache_pkg::*;
#(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned PlenWidth    = 56
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alloc_i,
    input  logic [TidWidth-1:0]     tid_i,
    input  logic                    nc_i,
    input  logic [PlenWidth-1:0]    paddr_i,
    input  logic                    grant_i,
    input  logic                    beat_i,
    input  logic                    last_i,
    input  logic [AxiDataWidth-1:0] data_i,
    input  logic                    err_i,
    output refill_slot_t            status_o,
    output logic [TidWidth-1:0]     tid_o,
    output logic [PlenWidth-1:0]    paddr_o,
    output logic [LineWidth-1:0]    cmpl_line_o,
    output logic                    cmpl_err_o
);

    localparam int unsigned Beats = beat_count(LineWidth, AxiDataWidth);
    localparam int unsigned CntW  = cnt_width(Beats);
    localparam int unsigned IdxW  = blen_width(Beats);

    slot_state_e             state_q, state_d;
    logic                    nc_q;
    logic [TidWidth-1:0]     tid_q;
    logic [PlenWidth-1:0]    paddr_q;
    logic [CntW-1:0]         cnt_q;
    logic [1:0]              err_code_q, err_code_d;
    logic [LineWidth-1:0]    line_q, line_d;
    logic [CntW-1:0]         exp_cnt;
    logic                    word_ok;
    logic                    live_beat;
    logic [IdxW-1:0]         widx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_FREE:    if (alloc_i)           state_d = SLOT_PENDING;
            SLOT_PENDING: if (grant_i)           state_d = SLOT_ISSUED;
            SLOT_ISSUED:  if (beat_i && last_i)  state_d = SLOT_FREE;
            default:                             state_d = SLOT_FREE;
        endcase
    end

    // Beat merge and error classification, evaluated for the beat in flight.
    always_comb begin
        exp_cnt   = nc_q ? CntW'(1) : CntW'(Beats);
        word_ok   = cnt_q < exp_cnt;
        widx      = nc_q ? '0 : cnt_q[IdxW-1:0];
        live_beat = beat_i && (state_q == SLOT_ISSUED);

        line_d = line_q;
        if (word_ok) begin
            line_d[widx*AxiDataWidth +: AxiDataWidth] = data_i;
        end

        err_code_d = err_code_q;
        if (err_code_q == ERR_NONE) begin
            if (err_i) begin
                err_code_d = ERR_RESP;
            end else if (!word_ok) begin
                err_code_d = ERR_OVERFLOW;
            end else if (last_i && ((cnt_q + CntW'(1)) < exp_cnt)) begin
                err_code_d = ERR_EARLY_LAST;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SLOT_FREE;
            nc_q       <= 1'b0;
            tid_q      <= '0;
            paddr_q    <= '0;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
            line_q     <= '0;
        end else begin
            state_q <= state_d;
            if (alloc_i && (state_q == SLOT_FREE)) begin
                nc_q       <= nc_i;
                tid_q      <= tid_i;
                paddr_q    <= paddr_i;
                cnt_q      <= '0;
                err_code_q <= ERR_NONE;
                line_q     <= '0;
            end else if (live_beat) begin
                line_q     <= line_d;
                err_code_q <= err_code_d;
                if (word_ok) begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    assign status_o    = refill_slot_t'{state: state_q, nc: nc_q};
    assign tid_o       = tid_q;
    assign paddr_o     = paddr_q;
    assign cmpl_line_o = line_d;
    assign cmpl_err_o  = (err_code_d != ERR_NONE);

endmodule

// File: rtl/icache_axi_refill_engine.sv
// Multi-outstanding icache refill engine: allocates slots for misses, issues
// one AXI read per slot (ID = slot index) and returns assembled lines.
module icache_axi_refill_engine
    import wt_cache_pkg::*;
#(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned NumTxn       = 2,
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned PlenWidth    = 56
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [PlenWidth-1:0]    req_paddr_i,
    input  logic                    req_nc_i,
    input  logic [TidWidth-1:0]     req_tid_i,
    output logic                    rd_req_o,
    input  logic                    rd_gnt_i,
    output logic [63:0]             rd_addr_o,
    output logic [blen_width(LineWidth/AxiDataWidth)-1:0] rd_blen_o,
    output logic [2:0]              rd_size_o,
    output logic [AxiIdWidth-1:0]   rd_id_o,
    input  logic                    rd_valid_i,
    input  logic                    rd_last_i,
    input  logic [AxiDataWidth-1:0] rd_data_i,
    input  logic [AxiIdWidth-1:0]   rd_id_i,
    input  logic                    rd_err_i,
    output logic                    rtrn_vld_o,
    output logic [LineWidth-1:0]    rtrn_data_o,
    output logic [TidWidth-1:0]     rtrn_tid_o,
    output logic                    rtrn_nc_o,
    output logic                    rtrn_err_o,
    output logic                    spurious_o,
    output logic                    busy_o
);

    // Handshakes: a request transfers on a cycle where req_valid_i & req_ready_o;
    // a read issues on rd_req_o & rd_gnt_i with address/blen/id held until then;
    // read beats have no backpressure, every rd_valid_i cycle is consumed.

    localparam int unsigned Beats = beat_count(LineWidth, AxiDataWidth);
    localparam int unsigned BlenW = blen_width(Beats);
    localparam int unsigned SlotW = (NumTxn > 1) ? $clog2(NumTxn) : 1;
    localparam logic [PlenWidth-1:0] LineMask = PlenWidth'((LineWidth / 8) - 1);
    localparam logic [PlenWidth-1:0] WordMask = PlenWidth'((AxiDataWidth / 8) - 1);

    refill_slot_t         slot_status [NumTxn];
    logic [TidWidth-1:0]  slot_tid    [NumTxn];
    logic [PlenWidth-1:0] slot_paddr  [NumTxn];
    logic [LineWidth-1:0] slot_line   [NumTxn];
    logic [NumTxn-1:0]    slot_cmpl_err;
    logic [NumTxn-1:0]    slot_alloc, slot_grant, slot_beat;
    logic [NumTxn-1:0]    slot_free, slot_pend, slot_live;

    logic                 any_free, any_pend, accept;
    logic [SlotW-1:0]     alloc_idx, issue_idx;
    logic                 hit;
    logic [LineWidth-1:0] ret_line;
    logic [TidWidth-1:0]  ret_tid;
    logic                 ret_nc, ret_err;

    for (genvar k = 0; k < NumTxn; k++) begin : g_slot
        assign slot_free[k]  = (slot_status[k].state == SLOT_FREE);
        assign slot_pend[k]  = (slot_status[k].state == SLOT_PENDING);
        assign slot_live[k]  = (slot_status[k].state == SLOT_ISSUED);
        assign slot_alloc[k] = accept && (alloc_idx == SlotW'(k));
        assign slot_grant[k] = rd_gnt_i && any_pend && (issue_idx == SlotW'(k));
        assign slot_beat[k]  = rd_valid_i && (rd_id_i == AxiIdWidth'(k));

        icache_refill_slot #(
            .LineWidth    (LineWidth),
            .AxiDataWidth (AxiDataWidth),
            .TidWidth     (TidWidth),
            .PlenWidth    (PlenWidth)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .alloc_i     (slot_alloc[k]),
            .tid_i       (req_tid_i),
            .nc_i        (req_nc_i),
            .paddr_i     (req_paddr_i),
            .grant_i     (slot_grant[k]),
            .beat_i      (slot_beat[k]),
            .last_i      (rd_last_i),
            .data_i      (rd_data_i),
            .err_i       (rd_err_i),
            .status_o    (slot_status[k]),
            .tid_o       (slot_tid[k]),
            .paddr_o     (slot_paddr[k]),
            .cmpl_line_o (slot_line[k]),
            .cmpl_err_o  (slot_cmpl_err[k])
        );
    end

    // Lowest-index selection for both allocation and issue.
    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        any_free  = 1'b0;
        any_pend  = 1'b0;
        for (int k = NumTxn - 1; k >= 0; k--) begin
            if (slot_free[k]) begin
                alloc_idx = SlotW'(k);
                any_free  = 1'b1;
            end
            if (slot_pend[k]) begin
                issue_idx = SlotW'(k);
                any_pend  = 1'b1;
            end
        end
    end

    assign req_ready_o = any_free && !any_pend;
    assign accept      = req_valid_i && req_ready_o;
    assign busy_o      = !(&slot_free);
    assign rd_size_o   = 3'($clog2(AxiDataWidth / 8));

    always_comb begin
        rd_req_o  = any_pend;
        rd_addr_o = '0;
        rd_blen_o = '0;
        rd_id_o   = '0;
        if (any_pend) begin
            if (slot_status[issue_idx].nc) begin
                rd_addr_o = 64'(slot_paddr[issue_idx] & ~WordMask);
                rd_blen_o = '0;
            end else begin
                rd_addr_o = 64'(slot_paddr[issue_idx] & ~LineMask);
                rd_blen_o = BlenW'(Beats - 1);
            end
            rd_id_o = AxiIdWidth'(issue_idx);
        end
    end

    always_comb begin
        hit      = 1'b0;
        ret_line = '0;
        ret_tid  = '0;
        ret_nc   = 1'b0;
        ret_err  = 1'b0;
        for (int k = 0; k < NumTxn; k++) begin
            if (slot_beat[k] && slot_live[k]) begin
                hit      = 1'b1;
                ret_line = slot_line[k];
                ret_tid  = slot_tid[k];
                ret_nc   = slot_status[k].nc;
                ret_err  = slot_cmpl_err[k];
            end
        end
    end

    // Return fields are zero whenever no return is being presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtrn_vld_o  <= 1'b0;
            rtrn_data_o <= '0;
            rtrn_tid_o  <= '0;
            rtrn_nc_o   <= 1'b0;
            rtrn_err_o  <= 1'b0;
            spurious_o  <= 1'b0;
        end else begin
            rtrn_vld_o  <= hit && rd_last_i;
            rtrn_data_o <= (hit && rd_last_i) ? ret_line : '0;
            rtrn_tid_o  <= (hit && rd_last_i) ? ret_tid : '0;
            rtrn_nc_o   <= hit && rd_last_i && ret_nc;
            rtrn_err_o  <= hit && rd_last_i && ret_err;
            spurious_o  <= rd_valid_i && !hit;
        end
    end

endmodule

// File: tb/tb_icache_axi_refill_engine.sv
// Directed bench for icache_axi_refill_engine: transaction-level model plus
// literal checks, and an 8-beat instance for the wide-line configuration.
module tb_icache_axi_refill_engine;

    localparam int NT    = 2;
    localparam int BEATS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, req_nc;
    logic [55:0]  req_paddr;
    logic [1:0]   req_tid;
    logic         rd_req, rd_gnt;
    logic [63:0]  rd_addr;
    logic [0:0]   rd_blen;
    logic [2:0]   rd_size;
    logic [3:0]   rd_id;
    logic         rd_valid, rd_last, rd_err;
    logic [63:0]  rd_data;
    logic [3:0]   rd_id_in;
    logic         rtrn_vld, rtrn_nc, rtrn_err, spurious, busy;
    logic [127:0] rtrn_data;
    logic [1:0]   rtrn_tid;

    icache_axi_refill_engine dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (req_valid), .req_ready_o (req_ready), .req_paddr_i (req_paddr),
        .req_nc_i (req_nc), .req_tid_i (req_tid),
        .rd_req_o (rd_req), .rd_gnt_i (rd_gnt), .rd_addr_o (rd_addr), .rd_blen_o (rd_blen),
        .rd_size_o (rd_size), .rd_id_o (rd_id),
        .rd_valid_i (rd_valid), .rd_last_i (rd_last), .rd_data_i (rd_data), .rd_id_i (rd_id_in),
        .rd_err_i (rd_err),
        .rtrn_vld_o (rtrn_vld), .rtrn_data_o (rtrn_data), .rtrn_tid_o (rtrn_tid),
        .rtrn_nc_o (rtrn_nc), .rtrn_err_o (rtrn_err), .spurious_o (spurious), .busy_o (busy)
    );

    logic         req8_valid, req8_ready, req8_nc;
    logic [55:0]  req8_paddr;
    logic [1:0]   req8_tid;
    logic         rd8_req, rd8_gnt;
    logic [63:0]  rd8_addr;
    logic [2:0]   rd8_blen, rd8_size;
    logic [3:0]   rd8_id, rd8_id_in;
    logic         rd8_valid, rd8_last, rd8_err;
    logic [31:0]  rd8_data;
    logic         rtrn8_vld, rtrn8_nc, rtrn8_err, spurious8, busy8;
    logic [255:0] rtrn8_data;
    logic [1:0]   rtrn8_tid;

    icache_axi_refill_engine #(.LineWidth(256), .AxiDataWidth(32)) dut8 (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (req8_valid), .req_ready_o (req8_ready), .req_paddr_i (req8_paddr),
        .req_nc_i (req8_nc), .req_tid_i (req8_tid),
        .rd_req_o (rd8_req), .rd_gnt_i (rd8_gnt), .rd_addr_o (rd8_addr), .rd_blen_o (rd8_blen),
        .rd_size_o (rd8_size), .rd_id_o (rd8_id),
        .rd_valid_i (rd8_valid), .rd_last_i (rd8_last), .rd_data_i (rd8_data), .rd_id_i (rd8_id_in),
        .rd_err_i (rd8_err),
        .rtrn_vld_o (rtrn8_vld), .rtrn_data_o (rtrn8_data), .rtrn_tid_o (rtrn8_tid),
        .rtrn_nc_o (rtrn8_nc), .rtrn_err_o (rtrn8_err), .spurious_o (spurious8), .busy_o (busy8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_valid  [NT];
    logic        m_issued [NT];
    logic [1:0]  m_tid    [NT];
    logic        m_nc     [NT];
    logic [55:0] m_paddr  [NT];
    logic [63:0] m_words  [NT][BEATS];
    int          m_cnt    [NT];
    logic        m_err    [NT];
    logic        e_vld, e_nc, e_err, e_spur;
    logic [127:0] e_data;
    logic [1:0]  e_tid;

    always @(posedge clk or posedge rst) begin
        int p, f, k, expn;
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                m_valid[i] = 0; m_issued[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
            end
            e_vld = 0; e_spur = 0; e_nc = 0; e_err = 0; e_tid = 0; e_data = 0;
        end else begin
            p = -1; f = -1;
            for (int i = NT - 1; i >= 0; i--) begin
                if (m_valid[i] && !m_issued[i]) p = i;
                if (!m_valid[i]) f = i;
            end
            e_vld = 0; e_spur = 0;
            if (rd_valid) begin
                k = int'(rd_id_in);
                if (k < NT && m_valid[k] && m_issued[k]) begin
                    expn = m_nc[k] ? 1 : BEATS;
                    if (m_cnt[k] < expn) begin
                        m_words[k][m_nc[k] ? 0 : m_cnt[k]] = rd_data;
                        m_cnt[k]++;
                    end else begin
                        m_err[k] = 1;
                    end
                    if (rd_err) m_err[k] = 1;
                    if (rd_last) begin
                        if (m_cnt[k] < expn) m_err[k] = 1;
                        e_vld = 1; e_tid = m_tid[k]; e_nc = m_nc[k]; e_err = m_err[k];
                        e_data = {m_words[k][1], m_words[k][0]};
                        m_valid[k] = 0; m_issued[k] = 0;
                    end
                end else begin
                    e_spur = 1;
                end
            end
            if (rd_gnt && p >= 0) m_issued[p] = 1;
            if (req_valid && f >= 0 && p < 0) begin
                m_valid[f] = 1; m_issued[f] = 0; m_tid[f] = req_tid; m_nc[f] = req_nc;
                m_paddr[f] = req_paddr; m_cnt[f] = 0; m_err[f] = 0;
                for (int j = 0; j < BEATS; j++) m_words[f][j] = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int p, f;
        bit any_v;
        if (!rst) begin
            p = -1; f = -1; any_v = 0;
            for (int i = NT - 1; i >= 0; i--) begin
                if (m_valid[i] && !m_issued[i]) p = i;
                if (!m_valid[i]) f = i;
                if (m_valid[i]) any_v = 1;
            end
            check("m_ready", req_ready, (f >= 0) && (p < 0));
            check("m_rd_req", rd_req, p >= 0);
            if (p >= 0) begin
                check("m_rd_addr", rd_addr, m_nc[p] ? (m_paddr[p] & ~56'h7) : (m_paddr[p] & ~56'hF));
                check("m_rd_blen", rd_blen, m_nc[p] ? 0 : 1);
                check("m_rd_id", rd_id, p);
            end
            check("m_rd_size", rd_size, 3);
            check("m_busy", busy, any_v);
            check("m_rtrn_vld", rtrn_vld, e_vld);
            if (e_vld) begin
                check("m_rtrn_data", rtrn_data, e_data);
                check("m_rtrn_tid", rtrn_tid, e_tid);
                check("m_rtrn_nc", rtrn_nc, e_nc);
                check("m_rtrn_err", rtrn_err, e_err);
            end
            check("m_spurious", spurious, e_spur);
        end
    end

    // Scoreboard of hand-computed returns: {err, nc, tid, data}.
    logic [131:0] exp_q[$];
    always @(negedge clk) begin
        logic [131:0] e;
        if (!rst && rtrn_vld) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", rtrn_vld, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ret", {rtrn_err, rtrn_nc, rtrn_tid, rtrn_data}, e);
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic send_req(input logic [55:0] a, input logic nc, input logic [1:0] tid);
        int n;
        n = 0;
        req_valid = 1; req_paddr = a; req_nc = nc; req_tid = tid;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", n < 40, 1);
        @(negedge clk);
        req_valid = 0; req_paddr = 0; req_nc = 0; req_tid = 0;
    endtask

    task automatic do_grant();
        int n;
        n = 0;
        while (!rd_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", n < 40, 1);
        rd_gnt = 1;
        @(negedge clk);
        rd_gnt = 0;
    endtask

    task automatic beat(input int id, input logic [63:0] d, input logic last, input logic err);
        rd_valid = 1; rd_id_in = 4'(id); rd_data = d; rd_last = last; rd_err = err;
        @(negedge clk);
        rd_valid = 0; rd_id_in = 0; rd_data = 0; rd_last = 0; rd_err = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = 0; req_paddr = 0; req_nc = 0; req_tid = 0;
        rd_gnt = 0; rd_valid = 0; rd_last = 0; rd_data = 0; rd_id_in = 0; rd_err = 0;
        req8_valid = 0; req8_paddr = 0; req8_nc = 0; req8_tid = 0;
        rd8_gnt = 0; rd8_valid = 0; rd8_last = 0; rd8_data = 0; rd8_id_in = 0; rd8_err = 0;

        #2;
        check("rst_ready", req_ready, 1);
        check("rst_rd_req", rd_req, 0);
        check("rst_rtrn_vld", rtrn_vld, 0);
        check("rst_spurious", spurious, 0);
        check("rst_busy", busy, 0);
        check("rst_rtrn_data", rtrn_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // line request, two beats
        send_req(56'h8000_1234, 0, 1);
        check("t1_rd_req", rd_req, 1);
        check("t1_addr", rd_addr, 64'h8000_1230);
        check("t1_blen", rd_blen, 1);
        check("t1_id", rd_id, 0);
        do_grant();
        beat(0, 64'hA, 0, 0);
        check("t1_no_early", rtrn_vld, 0);
        exp_q.push_back({1'b0, 1'b0, 2'd1, 64'hB, 64'hA});
        beat(0, 64'hB, 1, 0);
        check("t1_vld", rtrn_vld, 1);
        check("t1_data", rtrn_data, {64'hB, 64'hA});
        check("t1_tid", rtrn_tid, 1);

        // non-cacheable single word
        send_req(56'h1004, 1, 2);
        check("t2_addr", rd_addr, 64'h1000);
        check("t2_blen", rd_blen, 0);
        do_grant();
        exp_q.push_back({1'b0, 1'b1, 2'd2, 64'h0, 64'h55});
        beat(0, 64'h55, 1, 0);
        check("t2_nc", rtrn_nc, 1);
        check("t2_data", rtrn_data, 128'h55);

        // two outstanding, out-of-order completion, full-table stall
        send_req(56'h100, 0, 0);
        do_grant();
        send_req(56'h200, 0, 3);
        check("t3_id1", rd_id, 1);
        do_grant();
        check("t3_full", req_ready, 0);
        exp_q.push_back({1'b0, 1'b0, 2'd3, 64'h12, 64'h11});
        beat(1, 64'h11, 0, 0);
        check("t3_still_full", req_ready, 0);
        beat(1, 64'h12, 1, 0);
        check("t3_ret_tid", rtrn_tid, 3);
        check("t3_freed", req_ready, 1);
        send_req(56'h300, 0, 2);
        check("t3_reuse_id", rd_id, 1);
        exp_q.push_back({1'b0, 1'b0, 2'd0, 64'h22, 64'h21});
        beat(0, 64'h21, 0, 0);
        // grant on slot 1 and last beat on slot 0 in the same cycle
        rd_gnt = 1; rd_valid = 1; rd_id_in = 0; rd_data = 64'h22; rd_last = 1;
        @(negedge clk);
        rd_gnt = 0; rd_valid = 0; rd_id_in = 0; rd_data = 0; rd_last = 0;
        check("t3_sim_vld", rtrn_vld, 1);
        check("t3_sim_tid", rtrn_tid, 0);
        check("t3_sim_issued", rd_req, 0);
        exp_q.push_back({1'b0, 1'b0, 2'd2, 64'h32, 64'h31});
        beat(1, 64'h31, 0, 0);
        beat(1, 64'h32, 1, 0);

        // grant withheld: request fields stay stable
        send_req(56'h4_0000_0048, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_req", rd_req, 1);
            check("t4_addr", rd_addr, 64'h4_0000_0040);
            check("t4_blen", rd_blen, 1);
            check("t4_id", rd_id, 0);
            check("t4_ready", req_ready, 0);
            @(negedge clk);
        end
        do_grant();
        // error on beat 0
        exp_q.push_back({1'b1, 1'b0, 2'd1, 64'hE1, 64'hE0});
        beat(0, 64'hE0, 0, 1);
        beat(0, 64'hE1, 1, 0);
        check("t5_err", rtrn_err, 1);
        // beats for nonexistent / free slots
        beat(3, 64'hDEAD, 1, 0);
        check("t5_spur_id3", spurious, 1);
        check("t5_spur_noret", rtrn_vld, 0);
        beat(1, 64'hBEEF, 1, 0);
        check("t5_spur_free", spurious, 1);

        // early last: one beat of a two-beat line
        send_req(56'h500, 0, 3);
        do_grant();
        exp_q.push_back({1'b1, 1'b0, 2'd3, 64'h0, 64'h77});
        beat(0, 64'h77, 1, 0);
        check("t5_early_err", rtrn_err, 1);
        // overflow: third beat dropped
        send_req(56'h600, 0, 1);
        do_grant();
        exp_q.push_back({1'b1, 1'b0, 2'd1, 64'h62, 64'h61});
        beat(0, 64'h61, 0, 0);
        beat(0, 64'h62, 0, 0);
        beat(0, 64'h63, 1, 0);
        check("t5_ovf_data", rtrn_data, {64'h62, 64'h61});

        // reset in the middle of a burst
        send_req(56'h700, 0, 2);
        do_grant();
        beat(0, 64'h71, 0, 0);
        rst = 1;
        #1;
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_rd_req", rd_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_vld", rtrn_vld, 0);
        @(negedge clk);
        rst = 0;
        beat(0, 64'h72, 1, 0);
        check("t6_post_spur", spurious, 1);
        check("t6_post_vld", rtrn_vld, 0);

        // 256-bit line over 32-bit beats
        req8_valid = 1; req8_paddr = 56'h2000_0044; req8_nc = 0; req8_tid = 2;
        check("t6_8_ready", req8_ready, 1);
        @(negedge clk);
        req8_valid = 0;
        check("t6_8_addr", rd8_addr, 64'h2000_0040);
        check("t6_8_blen", rd8_blen, 7);
        check("t6_8_size", rd8_size, 2);
        check("t6_8_id", rd8_id, 0);
        rd8_gnt = 1;
        @(negedge clk);
        rd8_gnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd8_valid = 1; rd8_id_in = 0; rd8_data = 32'h1000_0000 + i; rd8_last = (i == 7);
            @(negedge clk);
        end
        rd8_valid = 0; rd8_last = 0; rd8_data = 0;
        check("t6_8_vld", rtrn8_vld, 1);
        check("t6_8_data", rtrn8_data,
              256'h10000007_10000006_10000005_10000004_10000003_10000002_10000001_10000000);
        check("t6_8_tid", rtrn8_tid, 2);
        check("t6_8_err", rtrn8_err, 0);
        check("t6_8_spur", spurious8, 0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
